// File: rtl/pito_apb_timer.sv
// pito_apb_timer: APB completer with a 32-bit prescaled up-counter,
// compare match / overflow sticky flags and a level interrupt.
// Zero-wait-state slave; read data is captured on the setup-phase edge.
module pito_apb_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  irq_o
);

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_COMPARE  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    logic [4:0]            offset;
    logic                  bad_addr;
    logic                  wr_en;
    logic                  rd_setup;
    logic                  wr_ctrl;
    logic                  wr_prescale;
    logic                  wr_count;
    logic                  wr_compare;
    logic                  wr_status;

    logic                  ctrl_en;
    logic                  ctrl_auto;
    logic                  ctrl_irq_en;
    logic [15:0]           prescale;
    logic [15:0]           pcnt;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] compare;
    logic                  st_match;
    logic                  st_ovf;

    logic                  tick;
    logic                  tick_eff;
    logic                  cmp_hit;
    logic                  at_max;
    logic                  match_set;
    logic                  ovf_set;
    logic [DATA_WIDTH-1:0] rd_mux;

    // Only the low five address bits are decoded; the rest are don't-care.
    logic                  unused_paddr;
    assign unused_paddr = ^paddr[ADDR_WIDTH-1:5];

    assign offset   = paddr[4:0];
    assign bad_addr = (offset[1:0] != 2'b00) || (offset > OFF_STATUS);
    assign wr_en    = psel & penable & pwrite & ~bad_addr;
    assign rd_setup = psel & ~penable & ~pwrite;

    assign wr_ctrl     = wr_en && (offset == OFF_CTRL);
    assign wr_prescale = wr_en && (offset == OFF_PRESCALE);
    assign wr_count    = wr_en && (offset == OFF_COUNT);
    assign wr_compare  = wr_en && (offset == OFF_COMPARE);
    assign wr_status   = wr_en && (offset == OFF_STATUS);

    assign pready  = 1'b1;
    assign pslverr = psel & penable & bad_addr;
    assign irq_o   = ctrl_irq_en & (st_match | st_ovf);

    // A software write to COUNT overrides the tick completely, flags included.
    assign tick      = ctrl_en && (pcnt == prescale);
    assign tick_eff  = tick & ~wr_count;
    assign cmp_hit   = (count == compare);
    assign at_max    = (count == '1);
    assign match_set = tick_eff & cmp_hit;
    // Wrapping past all-ones is an overflow unless a reload to 0 took over.
    assign ovf_set   = tick_eff & at_max & ~(cmp_hit & ctrl_auto);

    // Control register bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en     <= pwdata[0];
            ctrl_auto   <= pwdata[1];
            ctrl_irq_en <= pwdata[2];
        end
    end

    // Prescale reload value and compare value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            compare  <= '0;
        end else begin
            if (wr_prescale) prescale <= pwdata[15:0];
            if (wr_compare)  compare  <= pwdata;
        end
    end

    // Prescaler: restarts on COUNT/PRESCALE writes, freezes while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (wr_count || wr_prescale) begin
            pcnt <= '0;
        end else if (ctrl_en) begin
            pcnt <= (pcnt == prescale) ? 16'h0000 : pcnt + 16'h0001;
        end
    end

    // Main counter: increment wraps to 0 naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= pwdata;
        end else if (tick_eff) begin
            if (cmp_hit && ctrl_auto) count <= '0;
            else                      count <= count + 1'b1;
        end
    end

    // Sticky flags; a hardware set on the same edge beats a W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_match <= 1'b0;
            st_ovf   <= 1'b0;
        end else begin
            st_match <= match_set | (st_match & ~(wr_status & pwdata[0]));
            st_ovf   <= ovf_set   | (st_ovf   & ~(wr_status & pwdata[1]));
        end
    end

    // Read mux; unmapped or misaligned offsets return zero.
    always_comb begin
        rd_mux = '0;
        if (!bad_addr) begin
            case (offset)
                OFF_CTRL:     rd_mux[2:0]  = {ctrl_irq_en, ctrl_auto, ctrl_en};
                OFF_PRESCALE: rd_mux[15:0] = prescale;
                OFF_COUNT:    rd_mux       = count;
                OFF_COMPARE:  rd_mux       = compare;
                OFF_STATUS:   rd_mux[1:0]  = {st_ovf, st_match};
                default:      rd_mux       = '0;
            endcase
        end
    end

    // Read data is captured at setup and held until the next read setup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prdata <= '0;
        end else if (rd_setup) begin
            prdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pito_apb_timer.sv
// Directed bench for pito_apb_timer: register access, timer timing,
// flag precedence, bad-address handling and mid-transfer reset.
module tb_pito_apb_timer;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_PRESCALE = 32'h04;
    localparam logic [31:0] A_COUNT    = 32'h08;
    localparam logic [31:0] A_COMPARE  = 32'h0C;
    localparam logic [31:0] A_STATUS   = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq_o;

    int tests_run    = 0;
    int tests_failed = 0;

    pito_apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starting just after edge k, commits on edge k+2 and returns 1ns later.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic dummy;
        apb_write(addr, data, dummy);
    endtask

    // Setup edge is k+1 (data captured there), access edge k+2.
    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        data = prdata;
        err  = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_irq(input int max_cyc, output int n);
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (irq_o) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          n;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_pready", {31'd0, pready}, 32'd1);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        apb_read(A_CTRL, rd, err);     check("rst_ctrl", rd, 32'h0);
        apb_read(A_PRESCALE, rd, err); check("rst_prescale", rd, 32'h0);
        apb_read(A_COUNT, rd, err);    check("rst_count", rd, 32'h0);
        apb_read(A_COMPARE, rd, err);  check("rst_compare", rd, 32'h0);
        apb_read(A_STATUS, rd, err);   check("rst_status", rd, 32'h0);

        // Register field masking
        wr(A_CTRL, 32'hFFFF_FFF8);
        apb_read(A_CTRL, rd, err);     check("ctrl_mask", rd, 32'h0);
        wr(A_PRESCALE, 32'hABCD_0007);
        apb_read(A_PRESCALE, rd, err); check("prescale_mask", rd, 32'h0000_0007);
        wr(A_COMPARE, 32'hDEAD_BEEF);
        apb_read(A_COMPARE, rd, err);  check("compare_rw", rd, 32'hDEAD_BEEF);

        // Prescaled match with auto-reload: match every 24 cycles
        wr(A_PRESCALE, 32'd3);
        wr(A_COMPARE, 32'd5);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h7);
        wait_irq(40, n);
        check("match_latency", n, 32'd24);
        wr(A_STATUS, 32'h1);
        check("irq_after_w1c", {31'd0, irq_o}, 32'd0);
        wait_irq(40, n);
        check("match_repeat", n, 32'd22);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h3);

        // Overflow from 0xFFFF_FFFE with PRESCALE = 0
        wr(A_PRESCALE, 32'd0);
        wr(A_COMPARE, 32'h10);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h5);
        @(posedge clk); #1;
        check("ovf_irq_e1", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        check("ovf_irq_e2", {31'd0, irq_o}, 32'd1);
        apb_read(A_COUNT, rd, err);  check("ovf_count", rd, 32'h0);
        apb_read(A_STATUS, rd, err); check("ovf_status", rd, 32'h2);
        wr(A_STATUS, 32'h2);
        check("ovf_irq_clr", {31'd0, irq_o}, 32'd0);
        wr(A_CTRL, 32'h0);
        apb_read(A_STATUS, rd, err); check("ovf_status_clr", rd, 32'h0);

        // W1C of MATCH on the same edge as a new match (matches on E4, E8, ...)
        wr(A_PRESCALE, 32'd0);
        wr(A_COMPARE, 32'd3);
        wr(A_COUNT, 32'd0);
        wr(A_STATUS, 32'h3);
        wr(A_CTRL, 32'h7);
        repeat (6) begin @(posedge clk); #1; end
        wr(A_STATUS, 32'h1);
        check("w1c_race_irq", {31'd0, irq_o}, 32'd1);
        apb_read(A_STATUS, rd, err); check("w1c_race_status", rd, 32'h1);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h3);

        // COUNT write on a tick edge (ticks on E4, E8, ...)
        wr(A_PRESCALE, 32'd3);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h1);
        repeat (6) begin @(posedge clk); #1; end
        wr(A_COUNT, 32'h100);
        apb_read(A_COUNT, rd, err); check("cnt_wr_e9", rd, 32'h100);
        apb_read(A_COUNT, rd, err); check("cnt_wr_e11", rd, 32'h100);
        apb_read(A_COUNT, rd, err); check("cnt_wr_e13", rd, 32'h101);
        wr(A_CTRL, 32'h0);

        // Bad addresses
        wr(A_PRESCALE, 32'h1234);
        apb_read(A_PRESCALE, rd, err);
        check("good_rd_err", {31'd0, err}, 32'd0);
        check("good_rd_data", rd, 32'h1234);
        apb_read(32'h14, rd, err);
        check("bad_rd_err", {31'd0, err}, 32'd1);
        check("bad_rd_data", rd, 32'h0);
        apb_write(32'h06, 32'hFFFF_FFFF, err);
        check("bad_wr_err", {31'd0, err}, 32'd1);
        apb_read(A_PRESCALE, rd, err); check("bad_wr_prescale", rd, 32'h1234);
        apb_read(A_CTRL, rd, err);     check("bad_wr_ctrl", rd, 32'h0);
        apb_read(A_PRESCALE, rd, err);

        // Reset asserted mid-transfer
        wr(A_COMPARE, 32'h55);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_COMPARE; pwdata = 32'hAA;
        @(negedge clk);
        penable = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("async_rst_prdata", prdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst_n = 1'b1;
        apb_read(A_COMPARE, rd, err); check("rst_mid_compare", rd, 32'h0);
        wr(A_COMPARE, 32'h66);
        apb_read(A_COMPARE, rd, err); check("post_rst_compare", rd, 32'h66);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
